// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_lvl slice.
// clog2() is a constant function for deriving address widths from DEPTH;
// cw_of() gives the pointer/level width CW = clog2(DEPTH) + 1.
package fifo_pkg;

    function automatic int clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << r) < v) begin
                r = r + 1;
            end
        end
        return int'(r);
    endfunction

    function automatic int cw_of(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_lvl_if.sv
// Bus interface for fifo_lvl: write/read handshake, control and status.
// master: the side producing din/we/re/flush/clr_err and consuming status.
// slave : the FIFO itself.
interface fifo_lvl_if
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
);
    localparam int CW = cw_of(DEPTH);

    logic [WIDTH-1:0] din;
    logic             we;
    logic             re;
    logic             flush;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;
    logic [CW-1:0]    level;

    modport master (
        output din, we, re, flush, clr_err,
        input  dout, full, empty, almost_full, almost_empty,
               overflow, underflow, level
    );

    modport slave (
        input  din, we, re, flush, clr_err,
        output dout, full, empty, almost_full, almost_empty,
               overflow, underflow, level
    );

endinterface

// File: rtl/fifo_lvl_ram.sv
// DEPTH x WIDTH register file for fifo_lvl.
// Ports: cp2 (clock), ireset (sync active-low, clears all entries),
//        we/waddr/wdata (synchronous write), raddr/rdata (asynchronous read).
module fifo_lvl_ram
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                    cp2,
    input  logic                    ireset,
    input  logic                    we,
    input  logic [clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]        rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge cp2) begin
        if (!ireset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_lvl.sv
// Synchronous FIFO with level, almost-full/empty thresholds and sticky
// overflow/underflow flags.
// Ports: cp2 (clock, rising edge), ireset (sync active-low reset),
//        bus (fifo_lvl_if.slave: din/we/re/flush/clr_err in;
//             dout/full/empty/almost_full/almost_empty/overflow/underflow/level out).
// SYNC_OUT=1 adds one register stage on dout and every status output.
module fifo_lvl
    import fifo_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int WIDTH    = 8,
    parameter int SYNC_OUT = 0,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic       cp2,
    input  logic       ireset,
    fifo_lvl_if.slave  bus
);

    localparam int            CW   = cw_of(DEPTH);
    localparam int            AW   = CW - 1;
    localparam logic [CW-1:0] AF_L = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_L = CW'(AE_LEVEL);

    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             empty_c, full_c, af_c, ae_c;
    logic [CW-1:0]    level_c;
    logic             rd_ok, wr_ok, ram_we;
    logic [WIDTH-1:0] rdata;

    always_comb begin
        empty_c = (wr_ptr_q == rd_ptr_q);
        full_c  = (wr_ptr_q[CW-1] != rd_ptr_q[CW-1]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        // Pointer difference modulo 2*DEPTH is exactly the entry count.
        level_c = wr_ptr_q - rd_ptr_q;
        af_c    = (level_c >= AF_L);
        ae_c    = (level_c <= AE_L);

        rd_ok   = bus.re && !empty_c;
        // A full FIFO still takes a write when the same cycle pops.
        wr_ok   = bus.we && (!full_c || bus.re);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        ram_we   = 1'b0;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                ram_we   = 1'b1;
            end
            // Set events win over a same-cycle clear.
            if (bus.we && !wr_ok) begin
                ovf_d = 1'b1;
            end else if (bus.clr_err) begin
                ovf_d = 1'b0;
            end
            if (bus.re && empty_c) begin
                unf_d = 1'b1;
            end else if (bus.clr_err) begin
                unf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge cp2) begin
        if (!ireset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_lvl_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .cp2    (cp2),
        .ireset (ireset),
        .we     (ram_we),
        .waddr  (wr_ptr_q[AW-1:0]),
        .wdata  (bus.din),
        .raddr  (rd_ptr_q[AW-1:0]),
        .rdata  (rdata)
    );

    if (SYNC_OUT != 0) begin : g_sync
        logic [WIDTH-1:0] dout_q;
        logic [CW-1:0]    level_q;
        logic             full_q, empty_q, af_q, ae_q, ovf_o_q, unf_o_q;

        always_ff @(posedge cp2) begin
            if (!ireset) begin
                dout_q  <= '0;
                level_q <= '0;
                full_q  <= 1'b0;
                empty_q <= 1'b1;
                af_q    <= 1'b0;
                ae_q    <= 1'b1;
                ovf_o_q <= 1'b0;
                unf_o_q <= 1'b0;
            end else begin
                dout_q  <= rdata;
                level_q <= level_c;
                full_q  <= full_c;
                empty_q <= empty_c;
                af_q    <= af_c;
                ae_q    <= ae_c;
                ovf_o_q <= ovf_q;
                unf_o_q <= unf_q;
            end
        end

        assign bus.dout         = dout_q;
        assign bus.level        = level_q;
        assign bus.full         = full_q;
        assign bus.empty        = empty_q;
        assign bus.almost_full  = af_q;
        assign bus.almost_empty = ae_q;
        assign bus.overflow     = ovf_o_q;
        assign bus.underflow    = unf_o_q;
    end else begin : g_comb
        assign bus.dout         = rdata;
        assign bus.level        = level_c;
        assign bus.full         = full_c;
        assign bus.empty        = empty_c;
        assign bus.almost_full  = af_c;
        assign bus.almost_empty = ae_c;
        assign bus.overflow     = ovf_q;
        assign bus.underflow    = unf_q;
    end

endmodule

// File: tb/tb_fifo_lvl.sv
// Self-checking bench for fifo_lvl: two instances (SYNC_OUT=0 and 1) share
// stimulus; a queue-based model predicts the unregistered outputs and a
// one-cycle-delayed copy predicts the registered ones.
module tb_fifo_lvl;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int AF    = 3;
    localparam int AE    = 1;

    typedef struct {
        int        lvl;
        bit        emp;
        bit        ful;
        bit        af;
        bit        ae;
        bit        ovf;
        bit        unf;
        bit        dv;
        logic [7:0] dout;
    } exp_t;

    logic       cp2 = 1'b0;
    logic       rn_s = 1'b0;
    logic [7:0] din_s = '0;
    logic       we_s = 1'b0, re_s = 1'b0, flush_s = 1'b0, clr_s = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    fifo_lvl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) if0 ();
    fifo_lvl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) if1 ();

    assign if0.din = din_s;  assign if1.din = din_s;
    assign if0.we = we_s;    assign if1.we = we_s;
    assign if0.re = re_s;    assign if1.re = re_s;
    assign if0.flush = flush_s;  assign if1.flush = flush_s;
    assign if0.clr_err = clr_s;  assign if1.clr_err = clr_s;

    fifo_lvl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SYNC_OUT(0),
               .AF_LEVEL(AF), .AE_LEVEL(AE)) u0 (
        .cp2(cp2), .ireset(rn_s), .bus(if0));

    fifo_lvl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SYNC_OUT(1),
               .AF_LEVEL(AF), .AE_LEVEL(AE)) u1 (
        .cp2(cp2), .ireset(rn_s), .bus(if1));

    always #5 cp2 = ~cp2;

    // Reference model state.
    logic [7:0] q[$];
    bit   ovf_m = 0, unf_m = 0, zero_m = 1, mvalid = 0;
    exp_t sexp;

    function automatic exp_t model_out();
        exp_t e;
        e.lvl = q.size();
        e.emp = (q.size() == 0);
        e.ful = (q.size() == DEPTH);
        e.af  = (q.size() >= AF);
        e.ae  = (q.size() <= AE);
        e.ovf = ovf_m;
        e.unf = unf_m;
        if (q.size() > 0) begin
            e.dv = 1; e.dout = q[0];
        end else if (zero_m) begin
            e.dv = 1; e.dout = 8'h00;
        end else begin
            e.dv = 0; e.dout = 8'h00;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cmp(input string t, input exp_t e, input int lvl, input int emp,
                       input int ful, input int af, input int ae, input int ovf,
                       input int unf, input int dout);
        chk({t, ".level"}, lvl, e.lvl);
        chk({t, ".empty"}, emp, int'(e.emp));
        chk({t, ".full"}, ful, int'(e.ful));
        chk({t, ".almost_full"}, af, int'(e.af));
        chk({t, ".almost_empty"}, ae, int'(e.ae));
        chk({t, ".overflow"}, ovf, int'(e.ovf));
        chk({t, ".underflow"}, unf, int'(e.unf));
        if (e.dv) chk({t, ".dout"}, dout, int'(e.dout));
        chk({t, ".empty_and_full"}, int'(emp != 0 && ful != 0), 0);
    endtask

    // Model update on every rising edge.
    initial forever begin
        exp_t cur;
        @(posedge cp2);
        cur = model_out();
        if (!rn_s) begin
            q.delete(); ovf_m = 0; unf_m = 0; zero_m = 1; mvalid = 1;
            sexp = '{lvl: 0, emp: 1, ful: 0, af: 0, ae: 1, ovf: 0, unf: 0,
                     dv: 1, dout: 8'h00};
        end else begin
            sexp = cur;
            if (flush_s) begin
                q.delete(); ovf_m = 0; unf_m = 0;
            end else begin
                bit emp, ful, rd, wr;
                emp = (q.size() == 0);
                ful = (q.size() == DEPTH);
                rd  = re_s && !emp;
                wr  = we_s && (!ful || re_s);
                if (rd) void'(q.pop_front());
                if (wr) begin q.push_back(din_s); zero_m = 0; end
                if (we_s && !wr) ovf_m = 1; else if (clr_s) ovf_m = 0;
                if (re_s && emp) unf_m = 1; else if (clr_s) unf_m = 0;
            end
        end
    end

    // Compare both instances against the model on every falling edge.
    initial forever begin
        @(negedge cp2);
        if (mvalid) begin
            cmp("u0", model_out(), int'(if0.level), int'(if0.empty), int'(if0.full),
                int'(if0.almost_full), int'(if0.almost_empty), int'(if0.overflow),
                int'(if0.underflow), int'(if0.dout));
            cmp("u1", sexp, int'(if1.level), int'(if1.empty), int'(if1.full),
                int'(if1.almost_full), int'(if1.almost_empty), int'(if1.overflow),
                int'(if1.underflow), int'(if1.dout));
        end
    end

    task automatic cyc(input bit w, input bit r, input logic [7:0] d,
                       input bit f, input bit c, input bit n);
        we_s = w; re_s = r; din_s = d; flush_s = f; clr_s = c; rn_s = n;
        @(negedge cp2);
    endtask

    task automatic wr(input logic [7:0] d); cyc(1, 0, d, 0, 0, 1); endtask
    task automatic rd();                    cyc(0, 1, 8'h00, 0, 0, 1); endtask
    task automatic idle();                  cyc(0, 0, 8'h00, 0, 0, 1); endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [7:0] exp_rd [4];
    logic [7:0] d;

    initial begin
        exp_rd[0] = 8'h22; exp_rd[1] = 8'h33; exp_rd[2] = 8'h44; exp_rd[3] = 8'h55;
        @(negedge cp2);
        cyc(0, 0, 8'h00, 0, 0, 0);
        cyc(1, 1, 8'hFF, 1, 0, 0);

        // Reset values, both instances.
        chk("rst.u0.empty", int'(if0.empty), 1);
        chk("rst.u0.almost_empty", int'(if0.almost_empty), 1);
        chk("rst.u0.level", int'(if0.level), 0);
        chk("rst.u0.dout", int'(if0.dout), 0);
        chk("rst.u1.empty", int'(if1.empty), 1);
        chk("rst.u1.full", int'(if1.full), 0);

        // Fill to full, then refused write.
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        chk("fill.full", int'(if0.full), 1);
        chk("fill.level", int'(if0.level), 4);
        chk("fill.almost_full", int'(if0.almost_full), 1);
        wr(8'h66);
        chk("ovf.overflow", int'(if0.overflow), 1);
        chk("ovf.level", int'(if0.level), 4);
        chk("ovf.dout", int'(if0.dout), 8'h11);

        // Simultaneous pop and push on full.
        cyc(1, 1, 8'h55, 0, 0, 1);
        chk("fullrw.level", int'(if0.level), 4);
        for (int i = 0; i < 4; i++) begin
            chk("order.dout", int'(if0.dout), int'(exp_rd[i]));
            rd();
        end
        chk("drain.empty", int'(if0.empty), 1);

        // Underflow and clear.
        rd();
        chk("unf.underflow", int'(if0.underflow), 1);
        chk("unf.level", int'(if0.level), 0);
        cyc(0, 0, 8'h00, 0, 1, 1);
        chk("clr.underflow", int'(if0.underflow), 0);
        chk("clr.overflow", int'(if0.overflow), 0);

        // Write/read pairs across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            wr(d);
            chk("wrap.dout", int'(if0.dout), int'(d));
            rd();
            chk("wrap.empty", int'(if0.empty), 1);
        end

        // Flush beats a same-cycle write.
        wr(8'hA1); wr(8'hA2); wr(8'hA3);
        chk("flush.pre_level", int'(if0.level), 3);
        cyc(1, 0, 8'hA4, 1, 0, 1);
        chk("flush.level", int'(if0.level), 0);
        chk("flush.empty", int'(if0.empty), 1);
        idle();
        chk("flush.no_write", int'(if0.level), 0);

        // Registered-output latency.
        wr(8'hA5);
        chk("sync.u0_empty_n1", int'(if0.empty), 0);
        chk("sync.u1_empty_n1", int'(if1.empty), 1);
        idle();
        chk("sync.u1_empty_n2", int'(if1.empty), 0);
        chk("sync.u1_dout_n2", int'(if1.dout), 8'hA5);

        // Mid-stream reset with overflow set.
        wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
        idle();
        chk("prerst.u1_overflow", int'(if1.overflow), 1);
        cyc(1, 1, 8'h77, 0, 0, 0);
        chk("midrst.u0_level", int'(if0.level), 0);
        chk("midrst.u0_dout", int'(if0.dout), 0);
        chk("midrst.u1_full", int'(if1.full), 0);
        chk("midrst.u1_overflow", int'(if1.overflow), 0);
        chk("midrst.u1_empty", int'(if1.empty), 1);
        chk("midrst.u1_almost_empty", int'(if1.almost_empty), 1);
        chk("midrst.u1_dout", int'(if1.dout), 0);

        // Randomized traffic, with phases biased toward filling or draining.
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = ((i / 50) % 2 == 0) ? 70 : 30;
            cyc($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
                8'($urandom), $urandom_range(0, 39) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 96) != 0);
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_lvl.md
FIFO_LVL -- requirements
Module: fifo_lvl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning number of entries; legal values are powers of two from 2 to 256.
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning data bits per entry.
REQ-003 The block SHALL have parameter SYNC_OUT, default 0, meaning 1 registers dout and all status outputs by one cycle.
REQ-004 The block SHALL have parameter AF_LEVEL, default DEPTH-1, meaning the almost_full threshold (1..DEPTH).
REQ-005 The block SHALL have parameter AE_LEVEL, default 1, meaning the almost_empty threshold (0..DEPTH-1).
REQ-006 The block SHALL have port cp2, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-007 The block SHALL have port ireset, input, 1 bit, a synchronous active-low reset.
REQ-008 The block SHALL have ports din (input, WIDTH bits, write data), we (input, 1 bit, write request) and re (input, 1 bit, read/pop request).
REQ-009 The block SHALL have ports flush (input, 1 bit, discard contents) and clr_err (input, 1 bit, clear sticky error flags).
REQ-010 The block SHALL have ports dout (output, WIDTH bits, head entry), full (output, 1 bit) and empty (output, 1 bit).
REQ-011 The block SHALL have ports almost_full, almost_empty, overflow and underflow (outputs, 1 bit each).
REQ-012 The block SHALL have port level, output, CW=clog2(DEPTH)+1 bits, the current entry count 0..DEPTH.

Function
REQ-013 Read and write pointers SHALL be CW bits wide: the low CW-1 bits address storage and the MSB marks wrap.
REQ-014 empty SHALL be 1 when the pointers are equal.
REQ-015 full SHALL be 1 when the pointer MSBs differ and the low bits are equal.
REQ-016 A read SHALL be accepted iff re=1 and empty=0; the read pointer then increments, wrapping modulo 2*DEPTH.
REQ-017 A write SHALL be accepted iff we=1 and either full=0, or full=1 with re=1 (same-cycle pop frees a slot); din is then stored at the write pointer, which increments.
REQ-018 When empty=1, a simultaneous we and re SHALL accept only the write; there is no fall-through.
REQ-019 level SHALL be +1 on a write only, -1 on a read only, and unchanged when both or neither are accepted; it SHALL never exceed DEPTH or go below 0.
REQ-020 almost_full SHALL equal (level >= AF_LEVEL) and almost_empty SHALL equal (level <= AE_LEVEL).
REQ-021 overflow SHALL set when we=1 and the write is refused; underflow SHALL set when re=1 and empty=1; both flags SHALL be sticky.
REQ-022 clr_err=1 SHALL clear overflow and underflow next cycle; a same-cycle set event SHALL take priority over the clear.
REQ-023 flush SHALL override we and re, zero both pointers and level, and clear the error flags; storage contents SHALL be left unchanged.
REQ-024 With SYNC_OUT=0, dout SHALL be the entry at the read pointer combinationally, and status outputs SHALL be combinational from the pointers.
REQ-025 With SYNC_OUT=1, dout and every status output SHALL lag the SYNC_OUT=0 values by exactly one cp2 cycle.
REQ-026 Read latency SHALL be: data written in cycle N is visible on dout at N+1 (SYNC_OUT=0) or N+2 (SYNC_OUT=1) when the FIFO was empty.

Reset
REQ-027 While ireset=0 at a cp2 edge, pointers, level and storage SHALL clear to 0, dout to 0, and full, almost_full, overflow and underflow to 0.
REQ-028 While ireset=0, empty and almost_empty SHALL be 1, including the SYNC_OUT output registers.
REQ-029 Reset SHALL take priority over flush, we and re, and a transfer in progress during reset SHALL be discarded.

Structure
REQ-030 Shared package fifo_pkg SHALL hold the clog2 constant function and the pointer-width derivation CW.
REQ-031 Storage SHALL be a sub-module fifo_lvl_ram: a DEPTH x WIDTH register file with one synchronous write port and one asynchronous read port.

Verification (DEPTH=4, WIDTH=8, AF_LEVEL=3, AE_LEVEL=1)
REQ-032 The bench SHALL cover: write 0x11,0x22,0x33,0x44 -> full=1, level=4, almost_full=1; a fifth write with re=0 -> overflow=1 and contents unchanged.
REQ-033 The bench SHALL cover: full FIFO with we=1, re=1, din=0x55 -> dout 0x11 popped, level stays 4, and the read order is then 0x22,0x33,0x44,0x55.
REQ-034 The bench SHALL cover: re=1 on an empty FIFO -> underflow=1 and level=0; clr_err=1 -> underflow=0 next cycle.
REQ-035 The bench SHALL cover: 10 write/read pairs forcing pointer wrap -> data matches a reference model and empty/full are never both 1.
REQ-036 The bench SHALL cover: level=3 and flush=1 with we=1 -> level=0, empty=1 and no write taken.
REQ-037 The bench SHALL cover: SYNC_OUT=1 with a single write of 0xA5 into an empty FIFO -> empty falls and dout=0xA5 two cycles after the write; ireset=0 mid-stream -> all outputs at reset values next edge.
